// File: rtl/norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | norm_pkg : shared constants, types and helpers for the normalise pipeline   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package norm_pkg;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int NORM_WIDTH   = 36;
   localparam int NORM_EW      = 7;
   localparam int NORM_EXP_ADJ = 13;
   localparam int NORM_CNT_W   = cnt_width(NORM_WIDTH);

   typedef struct packed {
      logic [NORM_WIDTH-1:0]        mant;
      logic signed [NORM_EW-1:0]    exp;
      logic [NORM_CNT_W-1:0]        lz;
      logic                         zero;
   } norm_s1_t;

endpackage
`default_nettype wire

// File: rtl/lzc_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lzc_tree : recursive combinational leading-zero counter, any WIDTH >= 1     |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module lzc_tree #(
   parameter int WIDTH = 36,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] d,
   output logic [CNT_W-1:0] lz,
   output logic             all_zero
);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign lz       = CNT_W'(~d[0]);
         assign all_zero = ~d[0];
      end else begin : g_node
         localparam int c_p    = 1 << $clog2(WIDTH);
         localparam int c_half = c_p / 2;
         localparam int c_hw   = $clog2(c_half + 1);
         localparam int c_pw   = $clog2(c_p + 1);

         logic [c_p-1:0]  w_pad;
         logic [c_hw-1:0] w_hi_lz;
         logic [c_hw-1:0] w_lo_lz;
         logic            w_hi_z;
         logic            w_lo_z;
         logic [c_pw-1:0] w_lz_full;

         // zeros are appended below the LSB so the count of real bits is unchanged
         assign w_pad = c_p'(d) << (c_p - WIDTH);

         lzc_tree #(.WIDTH(c_half)) u_hi (
            .d        (w_pad[c_p-1:c_half]),
            .lz       (w_hi_lz),
            .all_zero (w_hi_z)
         );

         lzc_tree #(.WIDTH(c_half)) u_lo (
            .d        (w_pad[c_half-1:0]),
            .lz       (w_lo_lz),
            .all_zero (w_lo_z)
         );

         assign w_lz_full = w_hi_z ? (c_pw'(c_half) + c_pw'(w_lo_lz)) : c_pw'(w_hi_lz);
         assign all_zero  = w_hi_z & w_lo_z;
         assign lz        = all_zero ? CNT_W'(WIDTH) : CNT_W'(w_lz_full);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/norm_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | norm_pipe : 2-stage leading-zero count + normalise, valid/ready handshake   |
// | Option    : NORM_SUBNORM_CLAMP_EN limits the shift to keep exp >= EMIN      |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
module norm_pipe
   import norm_pkg::*;
#(
   parameter int WIDTH   = NORM_WIDTH,
   parameter int EW      = NORM_EW,
   parameter int EXP_ADJ = NORM_EXP_ADJ,
   parameter int EMIN    = 1,
   parameter int CNT_W   = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_mant,
   input  logic [EW-1:0]    in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_mant,
   output logic [EW-1:0]    out_exp,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_zero,
   output logic             out_subnorm
);

   localparam int c_xw = EW + CNT_W + 1;

   typedef struct packed {
      logic [WIDTH-1:0] mant;
      logic [EW-1:0]    exp;
      logic [CNT_W-1:0] lz;
      logic             zero;
   } s1_t;

   generate
      if (WIDTH < 2 || EMIN >= (1 << (EW - 1))) begin : g_param_err
         $error("norm_pipe: WIDTH must be >= 2 and EMIN must fit in EW bits");
      end
   endgenerate

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [CNT_W-1:0] w_lz;
   logic             w_zero;
   logic [CNT_W-1:0] w_shift;
   logic [WIDTH-1:0] w_mant;
   logic [c_xw-1:0]  w_exp_full;

   logic             r_s1_valid;
   s1_t              r_s1;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_mant;
   logic [EW-1:0]    r_exp;
   logic [CNT_W-1:0] r_cnt;
   logic             r_zero;

   assign w_s2_adv = ~r_s2_valid | out_ready;
   assign w_s1_adv = ~r_s1_valid | w_s2_adv;
   assign in_ready = w_s1_adv;

   lzc_tree #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
      .d        (in_mant),
      .lz       (w_lz),
      .all_zero (w_zero)
   );

`ifdef NORM_SUBNORM_CLAMP_EN
   int   w_lim;
   logic w_sub;
   logic r_sub;

   // shift only as far as the exponent can drop before reaching EMIN
   always_comb begin
      w_lim   = int'($signed(r_s1.exp)) + EXP_ADJ - EMIN;
      w_shift = r_s1.lz;
      if (w_lim < 0) begin
         w_shift = '0;
      end else if (w_lim < int'(r_s1.lz)) begin
         w_shift = CNT_W'(w_lim);
      end
      w_sub = (w_shift < r_s1.lz) & ~r_s1.zero;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sub <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         r_sub <= w_sub;
      end
   end

   assign out_subnorm = r_sub;
`else
   assign w_shift     = r_s1.lz;
   assign out_subnorm = 1'b0;
`endif

   assign w_mant     = r_s1.mant << w_shift;
   assign w_exp_full = c_xw'($signed(r_s1.exp)) - c_xw'(w_shift) + c_xw'(EXP_ADJ);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1.mant <= in_mant;
            r_s1.exp  <= in_exp;
            r_s1.lz   <= w_lz;
            r_s1.zero <= w_zero;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_mant     <= '0;
         r_exp      <= '0;
         r_cnt      <= '0;
         r_zero     <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_cnt  <= w_shift;
            r_zero <= r_s1.zero;
            // a zero significand carries no meaningful exponent
            r_mant <= r_s1.zero ? '0 : w_mant;
            r_exp  <= r_s1.zero ? '0 : EW'(w_exp_full);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_mant  = r_mant;
   assign out_exp   = r_exp;
   assign out_cnt   = r_cnt;
   assign out_zero  = r_zero;

endmodule
`default_nettype wire

// File: doc/norm_pipe.md
Name: norm_pipe

Overview:
- Parametrised, pipelined leading-zero-count plus normalise unit. Successor to the fixed 36-bit combinational count/shift pair in the fma16 datapath.
- Accepts an unnormalised significand and its exponent through a valid/ready handshake. Returns the left-justified significand, the adjusted exponent, the shift count and status flags two cycles later.
- Sits between the FMA adder and the rounder; supports backpressure from the rounder.

Parameters:
- WIDTH, 36, significand width in bits (>= 2)
- EW, 7, exponent width, two's complement
- EXP_ADJ, 13, constant added to the exponent after normalisation
- EMIN, 1, minimum normal exponent; used only when NORM_SUBNORM_CLAMP_EN is defined
- CNT_W, $clog2(WIDTH+1), width of the shift count; derived, do not override

Ports:
- clk, input, 1, sole clock; all state updates on posedge
- reset, input, 1, synchronous active-high reset
- in_valid, input, 1, input beat present
- in_ready, output, 1, unit can accept a beat this cycle
- in_mant, input, WIDTH, unnormalised significand
- in_exp, input, EW, signed exponent
- out_valid, output, 1, result beat present
- out_ready, input, 1, consumer accepts the beat
- out_mant, output, WIDTH, normalised significand
- out_exp, output, EW, adjusted exponent
- out_cnt, output, CNT_W, applied left-shift amount
- out_zero, output, 1, in_mant was all zeros
- out_subnorm, output, 1, shift was clamped; tied 0 without the macro

Behaviour:
- Reset (synchronous, active-high): both stage valids clear. Next cycle: out_valid=0, in_ready=1. All data registers clear to 0, so out_mant, out_exp, out_cnt, out_zero and out_subnorm read 0. Reset mid-operation drops in-flight beats silently.
- Stage 1 (S1) registers: in_mant, in_exp, raw leading-zero count lz (0..WIDTH), and the zero flag.
- Stage 2 (S2) registers: shifted significand, adjusted exponent, count and flags. All outputs are driven directly from S2 registers.
- Latency: exactly 2 cycles from an accepted input to out_valid, with no stall. Throughput is 1 beat per cycle.
- Handshake: a transfer happens on a cycle where valid && ready.
  - S2 advances when ~s2_valid | out_ready.
  - S1 advances when ~s1_valid | s2_advance.
  - in_ready = s1_advance. This is combinational from out_ready; no skid buffer.
  - While out_valid && ~out_ready, all out_* stay stable.
  - Beats are never dropped, duplicated or reordered.
- Count: lz = number of zeros above the most significant 1. All-zero input gives lz=WIDTH and zero=1.
- Normal path:
  - shift = lz
  - out_mant = in_mant << shift, truncated to WIDTH
  - out_exp = in_exp - shift + EXP_ADJ, computed at EW+CNT_W+1 bits, then truncated to EW bits (wrap, no saturation)
- Zero input: out_mant=0, out_cnt=WIDTH, out_exp=0, out_zero=1. The exponent formula is not applied.
- Simultaneous accept in S1 and emit from S2 in the same cycle is legal with a full pipe.

Optional Feature:
NORM_SUBNORM_CLAMP_EN
- Defined:
  - lim = in_exp + EXP_ADJ - EMIN, computed signed at full width.
  - shift = 0 if lim < 0; else min(lz, lim).
  - out_subnorm = 1 when shift < lz and the input is non-zero.
  - The result then has out_exp = EMIN (or the unshifted exponent when lim < 0) and a non-left-justified significand.
- Undefined: shift = lz always; out_subnorm tied 0; no EMIN logic is synthesised.

Decomposition:
- Package norm_pkg holds:
  - function cnt_width(w) returning $clog2(w+1)
  - the packed struct norm_s1_t {mant, exp, lz, zero}, parametrised through the package constants used by fma16 (36/7)
  - the default EXP_ADJ constant 13
- Sub-module lzc_tree: parametrised combinational leading-zero counter.
  - Recursive halving, valid-bit/count pairs, pads WIDTH to the next power of two.
  - Outputs lz and all_zero.
  - Instantiated once, in front of the S1 register.

Test Plan (WIDTH=36, EW=7, EXP_ADJ=13):
- in_mant=36'h8_0000_0000, in_exp=5, out_ready=1 -> 2 cycles later: out_mant=36'h8_0000_0000, out_cnt=0, out_exp=18, out_zero=0.
- in_mant=36'h0_0000_0001, in_exp=20 -> out_mant=36'h8_0000_0000, out_cnt=35, out_exp=7'h7E (-2).
- in_mant=0, in_exp=9 -> out_zero=1, out_cnt=36, out_mant=0, out_exp=0.
- Five back-to-back beats with out_ready=0 for cycles 2-5:
  - in_ready drops after two beats are held.
  - out_* stay stable while stalled.
  - All five beats emerge in order once out_ready=1.
- Pipe full, reset=1 for one cycle -> next cycle out_valid=0 and in_ready=1; dropped beats never appear.
- With NORM_SUBNORM_CLAMP_EN, EMIN=1: in_mant=1, in_exp=-10 -> lim=2, out_mant=36'h0_0000_0004, out_cnt=2, out_exp=1, out_subnorm=1.
